// File: rtl/systolic_feeder.sv
// Operand feeder for the systolic array edge: a FIFO of ROWS-word vectors, popped one per cycle
// into the skew chains, followed by a zero drain and a done pulse. Optional SYS_FEED_UNDERRUN_EN.
module systolic_feeder #(
    parameter int unsigned word_size = 8,
    parameter int unsigned ROWS      = 4,
    parameter int unsigned COLS      = 4,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned KW        = 16
) (
    input  logic                      clk,
    input  logic                      clear,
    input  logic                      start,
    input  logic [KW-1:0]             k_len,
    input  logic [word_size*ROWS-1:0] in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [word_size*ROWS-1:0] out_data,
    output logic                      out_valid,
    output logic                      busy,
    output logic                      done
`ifdef SYS_FEED_UNDERRUN_EN
    ,
    output logic                      underrun
`endif
);

    localparam int unsigned VW       = word_size * ROWS;
    localparam int unsigned AW       = $clog2(DEPTH);
    localparam int unsigned DrainLen = ROWS + COLS - 1;
    localparam int unsigned DW       = $clog2(DrainLen + 1);

    typedef enum logic [1:0] {StIdle, StFeed, StDrain, StDone} state_e;

    state_e          r_state, w_state_d;
    logic [VW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [AW:0]     r_count;
    logic [KW-1:0]   r_k_len, w_k_len_d;
    logic [KW-1:0]   r_fed, w_fed_d, w_fed_inc;
    logic [DW-1:0]   r_drain_cnt, w_drain_d;
    logic [VW-1:0]   r_out_data;
    logic            r_out_valid;
    logic            r_armed;
    logic            w_push, w_pop, w_empty, w_start_acc;

    assign w_empty     = (r_count == '0);
    assign in_ready    = !clear && (r_count < (AW+1)'(DEPTH));
    assign w_push      = in_valid && in_ready;
    assign w_pop       = (r_state == StFeed) && !w_empty;
    // A start held high across a whole pass must not launch a second one.
    assign w_start_acc = (r_state == StIdle) && start && r_armed;
    assign w_fed_inc   = r_fed + KW'(1);

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign busy      = (r_state != StIdle);
    assign done      = (r_state == StDone);

    always_comb begin
        w_state_d = r_state;
        w_k_len_d = r_k_len;
        w_fed_d   = r_fed;
        w_drain_d = r_drain_cnt;
        case (r_state)
            StIdle: begin
                if (w_start_acc) begin
                    w_k_len_d = k_len;
                    w_fed_d   = '0;
                    w_drain_d = '0;
                    w_state_d = (k_len == '0) ? StDrain : StFeed;
                end
            end
            StFeed: begin
                if (w_pop) begin
                    w_fed_d = w_fed_inc;
                    if (w_fed_inc == r_k_len) begin
                        w_state_d = StDrain;
                        w_drain_d = '0;
                    end
                end
            end
            StDrain: begin
                if (r_drain_cnt == DW'(DrainLen - 1)) begin
                    w_state_d = StDone;
                end else begin
                    w_drain_d = r_drain_cnt + DW'(1);
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state     <= StIdle;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_k_len     <= '0;
            r_fed       <= '0;
            r_drain_cnt <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_armed     <= 1'b1;
        end else begin
            r_state     <= w_state_d;
            r_k_len     <= w_k_len_d;
            r_fed       <= w_fed_d;
            r_drain_cnt <= w_drain_d;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            // Zero on every non-valid cycle keeps the MACs neutral.
            r_out_data  <= w_pop ? r_mem[r_rd_ptr] : '0;
            r_out_valid <= w_pop;
            if (w_start_acc) begin
                r_armed <= 1'b0;
            end else if (!start) begin
                r_armed <= 1'b1;
            end
        end
    end

`ifdef SYS_FEED_UNDERRUN_EN
    logic r_underrun;
    assign underrun = r_underrun;

    always_ff @(posedge clk) begin
        if (clear || w_start_acc) begin
            r_underrun <= 1'b0;
        end else if ((r_state == StFeed) && w_empty) begin
            r_underrun <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: expected vectors queued at issue, checked by a monitor.
module tb_systolic_feeder;

    localparam int unsigned WS    = 8;
    localparam int unsigned ROWS  = 4;
    localparam int unsigned COLS  = 4;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned KW    = 16;
    localparam int unsigned VW    = WS * ROWS;

    logic          clk = 1'b0;
    logic          clear;
    logic          start;
    logic [KW-1:0] k_len;
    logic [VW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] out_data;
    logic          out_valid;
    logic          busy;
    logic          done;
`ifdef SYS_FEED_UNDERRUN_EN
    logic          underrun;
`endif

    int            n_checks = 0;
    int            n_errors = 0;
    logic [VW-1:0] exp_q [$];
    bit            mon_en = 1'b0;

    always #5 clk = ~clk;

    systolic_feeder #(
        .word_size(WS),
        .ROWS     (ROWS),
        .COLS     (COLS),
        .DEPTH    (DEPTH),
        .KW       (KW)
    ) dut (
        .clk      (clk),
        .clear    (clear),
        .start    (start),
        .k_len    (k_len),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .busy     (busy),
        .done     (done)
`ifdef SYS_FEED_UNDERRUN_EN
        ,
        .underrun (underrun)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VW-1:0] vec(input int i);
        logic [31:0] v;
        v = 32'hA0B0C0D0 + 32'h01010101 * i;
        return VW'(v);
    endfunction

    task automatic push_one(input logic [VW-1:0] v);
        in_valid = 1'b1;
        in_data  = v;
        exp_q.push_back(v);
        tick();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic do_clear();
        clear    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("in_ready_during_clear", in_ready, 0);
        tick();
        clear = 1'b0;
        exp_q.delete();
        mon_en = 1'b1;
        @(negedge clk);
        chk("in_ready_after_clear", in_ready, 1);
        chk("busy_after_clear", busy, 0);
        chk("valid_after_clear", out_valid, 0);
        tick();
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            seen = (done === 1'b1);
            tick();
        end
        chk(name, seen, 1);
    endtask

    // Monitor: every real vector must match the queue head; every bubble must be all-zero.
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_unexpected: got %0h required no vector", out_data);
                end else begin
                    chk("sb_data", out_data, exp_q.pop_front());
                end
            end else begin
                chk("sb_bubble_zero", {out_valid, out_data}, 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        int vals;
        clear    = 1'b1;
        start    = 1'b0;
        k_len    = '0;
        in_data  = '0;
        in_valid = 1'b0;
        tick();

        // Three prefetched vectors, k_len=3.
        do_clear();
        for (int i = 0; i < 3; i++) push_one(vec(i));
        start = 1'b1;
        k_len = 16'd3;
        tick();
        start = 1'b0;
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            chk("t1_valid", out_valid, (j >= 2 && j <= 4));
            chk("t1_done", done, (j == 11));
            if (j == 12) chk("t1_busy_end", busy, 0);
            tick();
        end

        // Backpressure with a full FIFO.
        do_clear();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = vec(10 + i);
            @(negedge clk);
            chk("t2_ready_fill", in_ready, 1);
            exp_q.push_back(vec(10 + i));
            tick();
        end
        in_data = vec(18);
        @(negedge clk);
        chk("t2_ready_full", in_ready, 0);
        start = 1'b1;
        k_len = 16'd8;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("t2_ready_pop_cycle", in_ready, 0);
        tick();
        @(negedge clk);
        chk("t2_ready_after_pop", in_ready, 1);
        exp_q.push_back(vec(18));
        tick();
        in_valid = 1'b0;
        wait_done("t2_done", 40);
        chk("t2_surplus_queued", exp_q.size(), 1);

        // Underrun: vectors arrive at cycles 0,1,5,6.
        do_clear();
        start    = 1'b1;
        k_len    = 16'd4;
        in_valid = 1'b1;
        in_data  = vec(20);
        exp_q.push_back(vec(20));
        tick();
        start   = 1'b0;
        in_data = vec(21);
        exp_q.push_back(vec(21));
        tick();
        for (int c = 2; c <= 8; c++) begin
            if (c == 5 || c == 6) begin
                in_valid = 1'b1;
                in_data  = vec(22 + c - 5);
                exp_q.push_back(in_data);
            end else begin
                in_valid = 1'b0;
                in_data  = '0;
            end
            @(negedge clk);
            chk("t3_valid", out_valid, (c == 2 || c == 3 || c == 7 || c == 8));
            tick();
        end
        in_valid = 1'b0;
`ifdef SYS_FEED_UNDERRUN_EN
        chk("t3_underrun", underrun, 1);
`endif
        wait_done("t3_done", 20);

        // k_len=0 pass leaves the FIFO untouched.
`ifdef SYS_FEED_UNDERRUN_EN
        chk("t4_underrun_sticky", underrun, 1);
`endif
        push_one(vec(30));
        push_one(vec(31));
        start = 1'b1;
        k_len = 16'd0;
        tick();
        start = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            @(negedge clk);
            chk("t4_busy", busy, (j <= 8));
            chk("t4_valid", out_valid, 0);
            chk("t4_done", done, (j == 8));
            tick();
        end
`ifdef SYS_FEED_UNDERRUN_EN
        chk("t4_underrun_cleared", underrun, 0);
`endif
        start = 1'b1;
        k_len = 16'd2;
        tick();
        start = 1'b0;
        wait_done("t4_done2", 30);
        chk("t4_fifo_kept", exp_q.size(), 0);

        // clear mid-FEED after two vectors have come out.
        do_clear();
        for (int i = 0; i < 5; i++) push_one(vec(40 + i));
        start = 1'b1;
        k_len = 16'd5;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("t5_valid_j1", out_valid, 0);
        tick();
        @(negedge clk);
        chk("t5_valid_j2", out_valid, 1);
        tick();
        clear = 1'b1;
        @(negedge clk);
        chk("t5_valid_j3", out_valid, 1);
        tick();
        clear = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("t5_busy", busy, 0);
        chk("t5_valid", out_valid, 0);
        chk("t5_ready", in_ready, 1);
        tick();
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            tick();
        end
        chk("t5_no_done", dones, 0);
        start = 1'b1;
        k_len = 16'd1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t5_fifo_empty", out_valid, 0);
            tick();
        end
        push_one(vec(50));
        wait_done("t5_done", 20);
        chk("t5_sb_drained", exp_q.size(), 0);

        // start held high through the whole pass.
        do_clear();
        for (int i = 0; i < 3; i++) push_one(vec(60 + i));
        start = 1'b1;
        k_len = 16'd2;
        dones = 0;
        vals  = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            if (out_valid === 1'b1) vals++;
            tick();
        end
        chk("t6_one_done", dones, 1);
        chk("t6_two_vectors", vals, 2);
        chk("t6_idle", busy, 0);
        start = 1'b0;
        tick();
        start = 1'b1;
        k_len = 16'd1;
        tick();
        start = 1'b0;
        wait_done("t6_done2", 20);
        chk("t6_surplus_used", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
